// File: rtl/ext_mem_reader_pkg.sv
// Shared constants, state encoding and clamp helper for ext_mem_reader.
//   MB_*_BITS       : macroblock coordinate widths
//   EXT_BUF_MEM_*   : external frame-buffer address/data widths
//   PLANE_*         : plane codes on req_plane
//   *_MULT          : per-MB byte multipliers of the frame layout
package ext_mem_reader_pkg;

  localparam int unsigned MB_X_BITS              = 7;
  localparam int unsigned MB_Y_BITS              = 7;
  localparam int unsigned EXT_BUF_MEM_ADDR_WIDTH = 32;
  localparam int unsigned EXT_BUF_MEM_DATA_WIDTH = 32;

  localparam logic [1:0] PLANE_LUMA = 2'd0;
  localparam logic [1:0] PLANE_CB   = 2'd1;
  localparam logic [1:0] PLANE_CR   = 2'd2;

  localparam int unsigned FRAME_MULT = 384;
  localparam int unsigned CB_MULT    = 256;
  localparam int unsigned CR_MULT    = 320;

  // Signed width for window/picture coordinates; wider than any req_x/req_y + row
  localparam int unsigned CW = MB_X_BITS + MB_Y_BITS + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BASE,
    ST_ROWCALC,
    ST_ISSUE,
    ST_RECV,
    ST_EMIT,
    ST_DONE
  } state_e;

  // Clamp v into [0, hi]
  function automatic logic signed [CW-1:0] clamp_lo0(input logic signed [CW-1:0] v,
                                                     input logic signed [CW-1:0] hi);
    if (v < 0)       return '0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/ext_mem_reader_ref_row_buf.sv
// Word row buffer for one fetched window row with edge-replicating read mux.
//   wr_en_i/wr_idx_i/wr_data_i : burst data write port
//   rd_col_i                   : signed picture word column being emitted
//   a_i                        : picture word column held in entry 0
//   last_i                     : index of last valid entry (b-a)
//   ww_m1_i                    : last picture word column
//   rd_data_o_c                : combinational read word
module ext_mem_reader_ref_row_buf
  import ext_mem_reader_pkg::*;
#(
  parameter int unsigned MaxWordsLog2 = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en_i,
  input  logic [MaxWordsLog2-1:0]           wr_idx_i,
  input  logic [EXT_BUF_MEM_DATA_WIDTH-1:0] wr_data_i,
  input  logic signed [CW-1:0]              rd_col_i,
  input  logic signed [CW-1:0]              a_i,
  input  logic [MaxWordsLog2-1:0]           last_i,
  input  logic signed [CW-1:0]              ww_m1_i,
  output logic [EXT_BUF_MEM_DATA_WIDTH-1:0] rd_data_o_c
);

  localparam int unsigned NW = 2 ** MaxWordsLog2;

  logic [EXT_BUF_MEM_DATA_WIDTH-1:0] mem_q [NW];

  // Row storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Left of picture repeats pixel 0, right of picture repeats the last pixel
  always_comb begin
    rd_data_o_c = mem_q[MaxWordsLog2'(rd_col_i - a_i)];
    if (rd_col_i < 0)
      rd_data_o_c = {4{mem_q[0][7:0]}};
    else if (rd_col_i > ww_m1_i)
      rd_data_o_c = {4{mem_q[last_i][31:24]}};
  end

endmodule

// File: rtl/ext_mem_reader.sv
// Reference-window fetcher: one burst per window row from the frame buffer,
// rows/columns clamped to the picture, edges replicated, one word per cycle out.
//   start/req_*          : window request, latched in IDLE
//   pic_* / total_mbs_*  : picture geometry
//   busy/done            : request status
//   out_*                : streamed window words (row, word column)
//   ext_mem_reader_*     : burst read interface to the memory hub
module ext_mem_reader
  import ext_mem_reader_pkg::*;
#(
  parameter int unsigned MaxWordsLog2 = 3,
  parameter int unsigned MaxRowsLog2  = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [1:0]                        req_plane,
  input  logic [2:0]                        req_ref_pic,
  input  logic [MB_X_BITS+5:0]              req_x,
  input  logic [MB_Y_BITS+5:0]              req_y,
  input  logic [MaxWordsLog2-1:0]           req_words_minus1,
  input  logic [MaxRowsLog2-1:0]            req_rows_minus1,
  input  logic [MB_X_BITS:0]                pic_width_in_mbs,
  input  logic [MB_Y_BITS:0]                pic_height_in_map_units,
  input  logic [MB_X_BITS+MB_Y_BITS:0]      total_mbs_one_frame,
  output logic                              busy,
  output logic                              done,
  output logic                              out_valid,
  output logic [31:0]                       out_data,
  output logic [MaxRowsLog2-1:0]            out_row,
  output logic [MaxWordsLog2-1:0]           out_col,
  input  logic                              ext_mem_reader_ready,
  output logic                              ext_mem_reader_burst,
  output logic [7:0]                        ext_mem_reader_burst_len_minus1,
  output logic [EXT_BUF_MEM_ADDR_WIDTH-1:0] ext_mem_reader_addr,
  input  logic                              ext_mem_reader_valid,
  input  logic [EXT_BUF_MEM_DATA_WIDTH-1:0] ext_mem_reader_data
);

  localparam int unsigned AW = EXT_BUF_MEM_ADDR_WIDTH;

  state_e                   state_q, state_d;
  logic                     chroma_q, chroma_d;
  logic [2:0]               ref_cnt_q, ref_cnt_d;
  logic signed [CW-1:0]     xw_q, xw_d, y_q, y_d, a_q, a_d;
  logic [MaxWordsLog2-1:0]  n_q, n_d, k_q, k_d, wr_idx_q, wr_idx_d, last_q, last_d;
  logic [MaxRowsLog2-1:0]   rows_q, rows_d, row_q, row_d;
  logic [AW-1:0]            base_q, base_d;
  logic                     busy_q, busy_d, done_q, done_d, burst_q, burst_d;
  logic [7:0]               len_q, len_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic                     out_valid_q, out_valid_d;
  logic [31:0]              out_data_q, out_data_d;
  logic [MaxRowsLog2-1:0]   out_row_q, out_row_d;
  logic [MaxWordsLog2-1:0]  out_col_q, out_col_d;

  logic [AW-1:0]            t_aw, frame_size, plane_off, stride, row_addr;
  logic signed [CW-1:0]     ww_m1, h_m1, yc, a_c, b_c, n_s, row_s, k_s, rd_col;
  logic [31:0]              rd_word;
  logic                     wr_en;

  // Frame layout and per-row address datapath
  always_comb begin
    t_aw       = AW'(total_mbs_one_frame);
    frame_size = t_aw * AW'(FRAME_MULT);
    if (req_plane == PLANE_LUMA)    plane_off = '0;
    else if (req_plane == PLANE_CB) plane_off = t_aw * AW'(CB_MULT);
    else                            plane_off = t_aw * AW'(CR_MULT);

    ww_m1  = (chroma_q ? CW'({pic_width_in_mbs, 1'b0}) : CW'({pic_width_in_mbs, 2'b00})) - CW'(1);
    h_m1   = (chroma_q ? CW'({pic_height_in_map_units, 3'b000})
                       : CW'({pic_height_in_map_units, 4'b0000})) - CW'(1);
    stride = chroma_q ? AW'({pic_width_in_mbs, 3'b000}) : AW'({pic_width_in_mbs, 4'b0000});

    n_s    = CW'(n_q);
    row_s  = CW'(row_q);
    k_s    = CW'(k_q);
    yc     = clamp_lo0(y_q + row_s, h_m1);
    a_c    = clamp_lo0(xw_q, ww_m1);
    b_c    = clamp_lo0(xw_q + n_s, ww_m1);
    row_addr = base_q + AW'(yc) * stride + (AW'(a_c) << 2);
    rd_col = xw_q + k_s;
  end

  assign wr_en = (state_q == ST_RECV) && ext_mem_reader_valid;

  ext_mem_reader_ref_row_buf #(
    .MaxWordsLog2(MaxWordsLog2)
  ) u_row_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx_q),
    .wr_data_i  (ext_mem_reader_data),
    .rd_col_i   (rd_col),
    .a_i        (a_q),
    .last_i     (last_q),
    .ww_m1_i    (ww_m1),
    .rd_data_o_c(rd_word)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    chroma_d    = chroma_q;
    ref_cnt_d   = ref_cnt_q;
    xw_d        = xw_q;
    y_d         = y_q;
    a_d         = a_q;
    n_d         = n_q;
    k_d         = k_q;
    wr_idx_d    = wr_idx_q;
    last_d      = last_q;
    rows_d      = rows_q;
    row_d       = row_q;
    base_d      = base_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    burst_d     = burst_q;
    len_d       = len_q;
    addr_d      = addr_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          chroma_d  = (req_plane != PLANE_LUMA);
          ref_cnt_d = req_ref_pic;
          xw_d      = CW'($signed(req_x) >>> 2);
          y_d       = CW'($signed(req_y));
          n_d       = req_words_minus1;
          rows_d    = req_rows_minus1;
          row_d     = '0;
          base_d    = plane_off;
          busy_d    = 1'b1;
          state_d   = ST_BASE;
        end
      end
      // Frame base by repeated addition of the frame size
      ST_BASE: begin
        if (ref_cnt_q != 3'd0) begin
          base_d    = base_q + frame_size;
          ref_cnt_d = ref_cnt_q - 3'd1;
        end
        if (ref_cnt_q <= 3'd1) state_d = ST_ROWCALC;
      end
      ST_ROWCALC: begin
        addr_d   = row_addr;
        len_d    = 8'(b_c - a_c);
        last_d   = MaxWordsLog2'(b_c - a_c);
        a_d      = a_c;
        wr_idx_d = '0;
        burst_d  = 1'b1;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (ext_mem_reader_ready) begin
          burst_d = 1'b0;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (ext_mem_reader_valid) begin
          wr_idx_d = wr_idx_q + MaxWordsLog2'(1);
          if (wr_idx_q == last_q) begin
            k_d     = '0;
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        out_valid_d = 1'b1;
        out_data_d  = rd_word;
        out_row_d   = row_q;
        out_col_d   = k_q;
        k_d         = k_q + MaxWordsLog2'(1);
        if (k_q == n_q) begin
          if (row_q == rows_q) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + MaxRowsLog2'(1);
            state_d = ST_ROWCALC;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      chroma_q    <= 1'b0;
      ref_cnt_q   <= '0;
      xw_q        <= '0;
      y_q         <= '0;
      a_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      wr_idx_q    <= '0;
      last_q      <= '0;
      rows_q      <= '0;
      row_q       <= '0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      burst_q     <= 1'b0;
      len_q       <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      chroma_q    <= chroma_d;
      ref_cnt_q   <= ref_cnt_d;
      xw_q        <= xw_d;
      y_q         <= y_d;
      a_q         <= a_d;
      n_q         <= n_d;
      k_q         <= k_d;
      wr_idx_q    <= wr_idx_d;
      last_q      <= last_d;
      rows_q      <= rows_d;
      row_q       <= row_d;
      base_q      <= base_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      burst_q     <= burst_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign busy                            = busy_q;
  assign done                            = done_q;
  assign out_valid                       = out_valid_q;
  assign out_data                        = out_data_q;
  assign out_row                         = out_row_q;
  assign out_col                         = out_col_q;
  assign ext_mem_reader_burst            = burst_q;
  assign ext_mem_reader_burst_len_minus1 = len_q;
  assign ext_mem_reader_addr             = addr_q;

endmodule
